// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - serial byte-stream loader that fills instruction memory and releases the CPU
module instr_loader #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    // Word index must reach DEPTH_WORDS itself (the post-increment compare against N).
    localparam int          IDX_W   = $clog2(DEPTH_WORDS + 1);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

    logic [2:0]       state;
    logic [15:0]      word_cnt;
    logic [IDX_W-1:0] word_idx;
    logic [1:0]       byte_idx;
    logic [23:0]      asm_q;

    logic        fire;
    logic [31:0] len_full;
    logic [31:0] next_idx;
    logic [31:0] word_addr;

    assign byte_ready = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
    assign imem_we    = (state == S_WRITE);
    assign busy       = byte_ready || imem_we;
    assign done       = (state == S_DONE);
    assign cpu_rst_n  = (state == S_DONE);
    assign err        = (state == S_ERR);

    assign fire      = byte_valid && byte_ready;
    assign len_full  = {16'd0, word_cnt[15:8], byte_data};
    assign next_idx  = 32'(word_idx) + 32'd1;
    assign word_addr = BASE_ADDR + (32'(word_idx) << 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            word_cnt   <= 16'd0;
            word_idx   <= '0;
            byte_idx   <= 2'd0;
            asm_q      <= 24'd0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        word_idx <= '0;
                        byte_idx <= 2'd0;
                        state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: begin
                    if (fire) begin
                        word_cnt[15:8] <= byte_data;
                        state          <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (fire) begin
                        word_cnt[7:0] <= byte_data;
                        if (len_full == 32'd0 || len_full > DEPTH_L)
                            state <= S_ERR;
                        else
                            state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (fire) begin
                        asm_q    <= {asm_q[15:0], byte_data};
                        byte_idx <= byte_idx + 2'd1;
                        // Output registers are loaded here so they are stable for the whole WRITE cycle.
                        if (byte_idx == 2'd3) begin
                            imem_addr  <= word_addr;
                            imem_wdata <= {asm_q, byte_data};
                            state      <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    word_idx <= next_idx[IDX_W-1:0];
                    if (next_idx == {16'd0, word_cnt})
                        state <= S_DONE;
                    else
                        state <= S_DATA;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - randomized self-checking bench for instr_loader against a stream-level model
module tb_instr_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_ready, imem_we, cpu_rst_n, busy, done, err;
    logic [31:0] imem_addr, imem_wdata;

    instr_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0]  s[$];
    logic [31:0] exp_addr_q[$], exp_data_q[$];
    logic [31:0] log_addr[$], log_data[$];
    logic [31:0] last_addr = 32'd0, last_data = 32'd0;
    bit          prev_we = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
        chk({tag, "_we"},    32'(imem_we),    32'd0);
        chk({tag, "_addr"},  imem_addr,       32'd0);
        chk({tag, "_wdata"}, imem_wdata,      32'd0);
        chk({tag, "_cpurst"},32'(cpu_rst_n),  32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_done"},  32'(done),       32'd0);
        chk({tag, "_err"},   32'(err),        32'd0);
    endtask

    // Per-cycle compare against the expected write list of the load in flight.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk_reset_outputs("rst");
            prev_we = 1'b0;
        end else begin
            chk("ready_implies_busy", 32'(byte_ready && !busy), 32'd0);
            chk("addr_align", 32'(imem_addr[1:0]), 32'd0);
            chk("flag_exclusive", 32'(done && err), 32'd0);
            if (imem_we) begin
                chk("write_cycle_flags", 32'({busy, byte_ready}), 32'd2);
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_write", 32'd1, 32'd0);
                end else begin
                    last_addr = exp_addr_q.pop_front();
                    last_data = exp_data_q.pop_front();
                    chk("write_addr", imem_addr, last_addr);
                    chk("write_data", imem_wdata, last_data);
                end
                log_addr.push_back(imem_addr);
                log_data.push_back(imem_wdata);
            end else begin
                chk("hold_addr", imem_addr, last_addr);
                chk("hold_data", imem_wdata, last_data);
            end
            if (prev_we) begin
                chk("done_after_write", 32'(done), 32'(exp_addr_q.size() == 0));
                chk("cpurst_after_write", 32'(cpu_rst_n), 32'(exp_addr_q.size() == 0));
            end
            prev_we = imem_we;
        end
    end

    task automatic mk_stream(input int n);
        s.delete();
        s.push_back(8'(n >> 8));
        s.push_back(8'(n));
        if (n >= 1 && n <= 256)
            for (int i = 0; i < 4 * n; i++) s.push_back(8'($urandom));
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_cpurst", 32'(cpu_rst_n), 32'd0);
        chk("start_done", 32'(done), 32'd0);
        chk("start_err", 32'(err), 32'd0);
    endtask

    // Streams s[] into the DUT; abort_after >= 0 stops feeding after that many bytes.
    task automatic run_load(input int abort_after, input bit chaos);
        int n, idx, cyc;
        bit ok;
        n  = (int'(s[0]) << 8) | int'(s[1]);
        ok = (n != 0) && (n <= 256);
        log_addr.delete();
        log_data.delete();
        if (ok)
            for (int w = 0; w < n; w++) begin
                exp_addr_q.push_back(32'(w * 4));
                exp_data_q.push_back({s[2+4*w], s[3+4*w], s[4+4*w], s[5+4*w]});
            end
        do_start();
        idx = 0;
        cyc = 0;
        while (idx < s.size() && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (abort_after >= 0 && idx == abort_after) break;
            if (!byte_ready) begin
                byte_valid = 1'b1;
                byte_data  = 8'($urandom);
            end else begin
                byte_valid = chaos ? ($urandom_range(0, 2) != 0) : 1'b1;
                byte_data  = byte_valid ? s[idx] : 8'($urandom);
            end
            start = chaos && ($urandom_range(0, 7) == 0);
            if (byte_valid && byte_ready) idx++;
        end
        @(negedge clk);
        start      = 1'b0;
        byte_valid = 1'b0;
        if (abort_after >= 0) return;
        chk("stream_consumed", 32'(idx), 32'(s.size()));
        cyc = 0;
        while (!(done || err) && cyc < 200) begin
            @(negedge clk);
            byte_valid = 1'($urandom);
            byte_data  = 8'($urandom);
            cyc++;
        end
        repeat (3) @(negedge clk);
        byte_valid = 1'b0;
        chk("end_done", 32'(done), 32'(ok));
        chk("end_err", 32'(err), 32'(!ok));
        chk("end_cpurst", 32'(cpu_rst_n), 32'(ok));
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_ready", 32'(byte_ready), 32'd0);
        chk("writes_outstanding", 32'(exp_addr_q.size()), 32'd0);
        chk("write_count", 32'(log_addr.size()), ok ? 32'(n) : 32'd0);
    endtask

    initial begin
        #1;
        chk_reset_outputs("init");
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_autostart", 32'(busy), 32'd0);

        // Basic two-word load with literal expectations.
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        run_load(-1, 1'b0);
        chk("basic_w0_data", log_data.size() > 0 ? log_data[0] : 32'hDEAD, 32'h2008_0005);
        chk("basic_w0_addr", log_addr.size() > 0 ? log_addr[0] : 32'hDEAD, 32'h0000_0000);
        chk("basic_w1_data", log_data.size() > 1 ? log_data[1] : 32'hDEAD, 32'h8C09_0004);
        chk("basic_w1_addr", log_addr.size() > 1 ? log_addr[1] : 32'hDEAD, 32'h0000_0004);

        // Zero length, then over-length, then a valid one-word load recovers.
        s = '{8'h00, 8'h00};
        run_load(-1, 1'b0);
        s = '{8'h01, 8'h01};
        run_load(-1, 1'b0);
        s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_load(-1, 1'b0);
        chk("one_word_data", log_data.size() > 0 ? log_data[0] : 32'h0, 32'hDEAD_BEEF);

        // Backpressure: three words under random valid, held high through WRITE.
        mk_stream(3);
        run_load(-1, 1'b1);
        chk("bp_addr2", log_addr.size() > 2 ? log_addr[2] : 32'hDEAD, 32'h0000_0008);

        // Reset after two data bytes of the first word.
        mk_stream(2);
        run_load(4, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midload");
        exp_addr_q.delete();
        exp_data_q.delete();
        last_addr = 32'd0;
        last_data = 32'd0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("post_reset_idle", 32'(busy), 32'd0);
        chk("post_reset_nodone", 32'(done), 32'd0);
        mk_stream(4);
        run_load(-1, 1'b1);

        // Reload from DONE restarts at BASE_ADDR.
        mk_stream(2);
        run_load(-1, 1'b1);
        chk("reload_first_addr", log_addr.size() > 0 ? log_addr[0] : 32'hDEAD, 32'h0000_0000);

        // Random mix, including illegal lengths.
        for (int k = 0; k < 10; k++) begin
            int r, n;
            r = $urandom_range(0, 9);
            n = (r == 0) ? 0 : (r == 1) ? 257 + $urandom_range(0, 300) : $urandom_range(1, 6);
            mk_stream(n);
            run_load(-1, 1'b1);
        end

        // Full-depth load exercises counter width.
        mk_stream(256);
        run_load(-1, 1'b1);
        chk("full_last_addr", log_addr.size() > 255 ? log_addr[255] : 32'hDEAD, 32'h0000_03FC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the instruction memory capacity in 32-bit words.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of the first word written.
REQ-003 clk  input  1  clock; all state changes on its positive edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin a load.
REQ-006 byte_valid  input  1  byte_data holds a valid stream byte.
REQ-007 byte_data  input  8  serial program stream byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_we  output  1  instruction memory write strobe.
REQ-010 imem_addr  output  32  instruction memory byte address, always a multiple of 4.
REQ-011 imem_wdata  output  32  instruction word to write.
REQ-012 cpu_rst_n  output  1  active-low reset to the CPU; low until a load completes.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  last load completed successfully.
REQ-015 err  output  1  last load was rejected because of its length header.

Function
REQ-016 A byte SHALL be consumed only on a clk edge where byte_valid and byte_ready are both 1; when byte_ready is 0, byte_valid SHALL be ignored and the byte SHALL NOT be consumed.
REQ-017 Stream format SHALL be a 16-bit word count N (high byte first), followed by 4*N bytes, each word big-endian (first byte becomes imem_wdata[31:24]).
REQ-018 FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE and ERR.
REQ-019 IDLE, DONE, ERR: byte_ready=0; start SHALL clear the word index, byte index, done and err, and go to LEN_HI.
REQ-020 LEN_HI: byte_ready=1; a consumed byte SHALL be stored as N[15:8], then go to LEN_LO.
REQ-021 LEN_LO: byte_ready=1; a consumed byte SHALL be stored as N[7:0]; if N==0 or N>DEPTH_WORDS go to ERR, else go to DATA.
REQ-022 DATA: byte_ready=1; each consumed byte SHALL be shifted into the assembly register; on the 4th byte go to WRITE on the next edge.
REQ-023 WRITE: lasts exactly one cycle with byte_ready=0, imem_we=1, imem_addr=BASE_ADDR+4*word_index and imem_wdata=the assembled word.
REQ-024 On leaving WRITE the word index SHALL increment; if the incremented index equals N go to DONE, else go to DATA.
REQ-025 imem_we SHALL be 1 only in WRITE; outside WRITE, imem_addr and imem_wdata SHALL hold their last values.
REQ-026 busy SHALL be 1 exactly in LEN_HI, LEN_LO, DATA and WRITE.
REQ-027 done and cpu_rst_n SHALL be 1 exactly in DONE.
REQ-028 err SHALL be 1 exactly in ERR.
REQ-029 start SHALL be ignored while busy=1.
REQ-030 A start issued in DONE SHALL drive cpu_rst_n to 0 from the next cycle, and addresses SHALL restart at BASE_ADDR.
REQ-031 No timeout SHALL exist; the loader waits indefinitely for bytes, and only reset aborts a load.
REQ-032 Internal counters SHALL be sized for DEPTH_WORDS and SHALL NOT wrap within a legal load.

Reset
REQ-033 While rst_n=0, regardless of clk: state=IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0, and all counters cleared.
REQ-034 Reset asserted mid-load SHALL abandon the load with no further write; after reset is released a new start is required.

Verification
REQ-035 Basic load: start, stream 00 02 20 08 00 05 8C 09 00 04 -> writes 0x20080005@0x0 then 0x8C090004@0x4, one imem_we pulse each; done=1 and cpu_rst_n=1 the cycle after the second write.
REQ-036 Zero length: stream 00 00 -> err=1, no imem_we pulse, cpu_rst_n stays 0, byte_ready=0.
REQ-037 Over-length with DEPTH_WORDS=256: stream 01 01 -> err=1, no write; a following start with a valid 1-word stream -> err=0 and done=1.
REQ-038 Backpressure: byte_valid held high across the WRITE cycle and toggled randomly elsewhere -> no byte lost or duplicated; 3-word image written exactly at 0x0, 0x4, 0x8.
REQ-039 Reset mid-DATA after 2 of 4 bytes -> all outputs at reset values immediately, no write; a subsequent full load succeeds.
REQ-040 Reload from DONE: start -> cpu_rst_n=0 on the next cycle, busy=1, first write at BASE_ADDR, done reasserted at the end of the load.
